// File: rtl/sobel_axis_out.sv
// Sobel magnitude output stage: per-lane saturate/binarize, small beat FIFO,
// AXI-Stream master with frame length checking and completed-frame counting.
module sobel_axis_out #(
   parameter int PIXEL       = 3,
   parameter int DATAWIDTH   = 8,
   parameter int DEPTH       = 4,
   parameter int THRESHOLD   = 0,
   parameter int FRAME_BEATS = 16
) (
   input  logic                           clk,
   input  logic                           ARESET,
   input  logic [DATAWIDTH*2*PIXEL-1:0]   packed_sum,
   input  logic                           i_strobe,
   input  logic                           in_tlast,
   output logic                           o_busy,
   output logic [DATAWIDTH*PIXEL-1:0]     m_axis_tdata,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tlast,
   output logic                           o_frame_err,
   output logic [15:0]                    o_frame_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int BW = $clog2(FRAME_BEATS + 1);
   localparam int IW = 2 * DATAWIDTH;
   localparam logic [IW-1:0] THR    = IW'(THRESHOLD);
   localparam logic [BW-1:0] FB_LEN = BW'(FRAME_BEATS);
   localparam logic [CW-1:0] FULL   = CW'(DEPTH);

   logic [DEPTH-1:0][DATAWIDTH*PIXEL-1:0] mem_data;
   logic [DEPTH-1:0]                      mem_last;
   logic [AW-1:0]                         wr_ptr, rd_ptr;
   logic [CW-1:0]                         count;
   logic [BW-1:0]                         beat_cnt, beat_nxt;
   logic [DATAWIDTH*PIXEL-1:0]            conv;
   logic                                  push, pop;

   // Lane conversion: saturate to the output width, or binarize when a threshold is set.
   for (genvar i = 0; i < PIXEL; i++) begin : g_lane
      logic [IW-1:0] lane;
      assign lane = packed_sum[IW*i +: IW];
      if (THRESHOLD == 0) begin : g_sat
         assign conv[DATAWIDTH*i +: DATAWIDTH] = (lane[IW-1:DATAWIDTH] != '0) ? '1
                                                : lane[DATAWIDTH-1:0];
      end else begin : g_bin
         assign conv[DATAWIDTH*i +: DATAWIDTH] = (lane >= THR) ? '1 : '0;
      end
   end

   assign o_busy        = (count == FULL);
   assign m_axis_tvalid = (count != '0);
   assign m_axis_tdata  = mem_data[rd_ptr];
   assign m_axis_tlast  = mem_last[rd_ptr];
   assign push          = i_strobe & ~o_busy;
   assign pop           = m_axis_tvalid & m_axis_tready;
   assign beat_nxt      = beat_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (ARESET) begin
         mem_data    <= '0;
         mem_last    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         beat_cnt    <= '0;
         o_frame_err <= 1'b0;
         o_frame_cnt <= '0;
      end else begin
         if (push) begin
            mem_data[wr_ptr] <= conv;
            mem_last[wr_ptr] <= in_tlast;
            wr_ptr           <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            // A frame ends either at tlast or at the expected length; any disagreement is an error.
            if (in_tlast || beat_nxt == FB_LEN) begin
               beat_cnt <= '0;
               if (in_tlast != (beat_nxt == FB_LEN)) o_frame_err <= 1'b1;
            end else begin
               beat_cnt <= beat_nxt;
            end
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (m_axis_tlast) o_frame_cnt <= o_frame_cnt + 16'd1;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_sobel_axis_out.sv
// Bench for sobel_axis_out: two instances (saturating and binarizing) share
// stimulus and are compared every cycle against a queue-based model.
module tb_sobel_axis_out;

   localparam int PIXEL = 3;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int FB    = 16;
   localparam int THR1  = 'h80;
   localparam int SW    = 2 * DW * PIXEL;
   localparam int OW    = DW * PIXEL;

   typedef struct packed {
      logic [SW-1:0] sum;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          areset, strobe, tlast_in, tready;
   logic [SW-1:0] sum;
   logic          busy0, busy1, tv0, tv1, tl0, tl1, err0, err1;
   logic [OW-1:0] td0, td1;
   logic [15:0]   fc0, fc1;

   beat_t q[$];
   int    n_in, fcnt_m;
   bit    err_m;
   int    checks, errors;

   always #5 clk = ~clk;

   sobel_axis_out #(.PIXEL(PIXEL), .DATAWIDTH(DW), .DEPTH(DEPTH), .THRESHOLD(0),
                    .FRAME_BEATS(FB)) u_dut0 (
      .clk(clk), .ARESET(areset), .packed_sum(sum), .i_strobe(strobe), .in_tlast(tlast_in),
      .o_busy(busy0), .m_axis_tdata(td0), .m_axis_tvalid(tv0), .m_axis_tready(tready),
      .m_axis_tlast(tl0), .o_frame_err(err0), .o_frame_cnt(fc0));

   sobel_axis_out #(.PIXEL(PIXEL), .DATAWIDTH(DW), .DEPTH(DEPTH), .THRESHOLD(THR1),
                    .FRAME_BEATS(FB)) u_dut1 (
      .clk(clk), .ARESET(areset), .packed_sum(sum), .i_strobe(strobe), .in_tlast(tlast_in),
      .o_busy(busy1), .m_axis_tdata(td1), .m_axis_tvalid(tv1), .m_axis_tready(tready),
      .m_axis_tlast(tl1), .o_frame_err(err1), .o_frame_cnt(fc1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Reference conversion straight from the lane rules, using integer arithmetic.
   function automatic logic [OW-1:0] conv(input logic [SW-1:0] s, input int thr);
      logic [OW-1:0] r;
      int v, o;
      r = '0;
      for (int i = 0; i < PIXEL; i++) begin
         v = int'(s[2*DW*i +: 2*DW]);
         if (thr == 0) o = (v > 255) ? 255 : v;
         else          o = (v >= thr) ? 255 : 0;
         r[DW*i +: DW] = DW'(o);
      end
      return r;
   endfunction

   function automatic logic [SW-1:0] rand_sum();
      logic [SW-1:0] s;
      for (int i = 0; i < PIXEL; i++)
         s[2*DW*i +: 2*DW] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 16'hFFFF))
                                                         : 16'($urandom_range(0, 16'h1FF));
      return s;
   endfunction

   task automatic compare(input bit rst);
      chk("tvalid0", 32'(tv0), 32'(q.size() > 0));
      chk("tvalid1", 32'(tv1), 32'(q.size() > 0));
      chk("busy0", 32'(busy0), 32'(q.size() == DEPTH));
      chk("busy1", 32'(busy1), 32'(q.size() == DEPTH));
      chk("err0", 32'(err0), 32'(err_m));
      chk("err1", 32'(err1), 32'(err_m));
      chk("fcnt0", 32'(fc0), 32'(fcnt_m));
      chk("fcnt1", 32'(fc1), 32'(fcnt_m));
      if (q.size() > 0) begin
         chk("tdata0", 32'(td0), 32'(conv(q[0].sum, 0)));
         chk("tdata1", 32'(td1), 32'(conv(q[0].sum, THR1)));
         chk("tlast0", 32'(tl0), 32'(q[0].last));
         chk("tlast1", 32'(tl1), 32'(q[0].last));
      end
      if (rst) begin
         chk("rst_tdata", 32'(td0), 32'd0);
         chk("rst_tlast", 32'(tl0), 32'd0);
      end
   endtask

   task automatic step(input bit rst, input bit stb, input bit last,
                       input logic [SW-1:0] s, input bit rdy);
      bit acc, pop;
      areset = rst; strobe = stb; tlast_in = last; sum = s; tready = rdy;
      acc = stb && (q.size() < DEPTH) && !rst;
      pop = (q.size() > 0) && rdy;
      @(posedge clk); #1;
      if (rst) begin
         q.delete(); n_in = 0; err_m = 0; fcnt_m = 0;
      end else begin
         if (pop) begin
            if (q[0].last) fcnt_m = (fcnt_m + 1) % 65536;
            void'(q.pop_front());
         end
         if (acc) begin
            q.push_back('{sum: s, last: last});
            n_in++;
            if (last) begin
               if (n_in != FB) err_m = 1;
               n_in = 0;
            end else if (n_in == FB) begin
               err_m = 1;
               n_in = 0;
            end
         end
      end
      compare(rst);
   endtask

   initial begin
      checks = 0; errors = 0; n_in = 0; fcnt_m = 0; err_m = 0;
      areset = 1; strobe = 0; tlast_in = 0; tready = 0; sum = '0;
      step(1, 0, 0, '0, 0);
      step(1, 0, 0, '0, 0);

      // Saturation and binarization of known lanes
      step(0, 1, 0, {16'h0100, 16'h00FF, 16'h0050}, 1);
      chk("sat_tdata", 32'(td0), 32'hFFFF50);
      step(0, 1, 0, {16'h0300, 16'h0080, 16'h007F}, 1);
      chk("bin_tdata", 32'(td1), 32'hFFFF00);
      step(0, 0, 0, '0, 1);

      // Back-pressure: fill, drop the fifth, then drain in order
      step(1, 0, 0, '0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, rand_sum(), 0);
         if (i == 3) chk("busy_full", 32'(busy0), 32'd1);
      end
      step(0, 0, 0, '0, 1);
      chk("busy_after_pop", 32'(busy0), 32'd0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1);
      chk("drained", 32'(tv0), 32'd0);

      // Steady state at DEPTH-1 with push and pop every cycle
      for (int i = 0; i < 3; i++) step(0, 1, 0, rand_sum(), 0);
      for (int i = 0; i < 10; i++) step(0, 1, 0, rand_sum(), 1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1);

      // Correct frame, then a short frame
      step(1, 0, 0, '0, 0);
      for (int i = 1; i <= FB; i++) step(0, 1, i == FB, rand_sum(), 1);
      step(0, 0, 0, '0, 1);
      chk("frame_cnt", 32'(fc0), 32'd1);
      chk("frame_ok", 32'(err0), 32'd0);
      for (int i = 1; i <= FB - 1; i++) step(0, 1, i == FB - 1, rand_sum(), 1);
      step(0, 0, 0, '0, 1);
      chk("frame_short", 32'(err0), 32'd1);

      // Reset with beats queued, then a normal beat
      for (int i = 0; i < 3; i++) step(0, 1, 0, rand_sum(), 0);
      step(1, 1, 0, rand_sum(), 0);
      chk("rst_tvalid", 32'(tv0), 32'd0);
      chk("rst_err", 32'(err0), 32'd0);
      step(0, 1, 1, {16'h0001, 16'h0002, 16'h0003}, 0);
      chk("post_rst", 32'(td0), 32'h010203);

      // Random traffic
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
              $urandom_range(0, 7) == 0, rand_sum(), $urandom_range(0, 9) < 6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
